// File: rtl/peripheral_bcd_scan_pkg.sv
// peripheral_bcd_scan_pkg: register map, FSM encoding, STATUS bits and segment constants
package peripheral_bcd_scan_pkg;
  localparam int ADDR_CTRL = 0;
  localparam int ADDR_VALUE = 2;
  localparam int ADDR_DPMASK = 4;
  localparam int ADDR_STATUS = 6;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVF = 2;
  // 27-bit operands need at most nine BCD digits
  localparam int BCD_N = 9;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE_ST} state_t;
  function automatic logic [4*BCD_N-1:0] dabble(input logic [4*BCD_N-1:0] b);
    logic [4*BCD_N-1:0] r;
    r = b;
    for (int i = 0; i < BCD_N; i++) r[4*i+:4] = (r[4*i+:4] >= 4'd5) ? r[4*i+:4] + 4'd3 : r[4*i+:4];
    return r;
  endfunction
endpackage

// File: rtl/peripheral_bcd_scan_seg_decode.sv
// bcd_seg_decode: BCD digit to active-low segments {g,f,e,d,c,b,a}
module bcd_seg_decode
  import peripheral_bcd_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segs
);
  always_comb begin
    case (digit)
      4'd0: segs = 7'b1000000;
      4'd1: segs = 7'b1111001;
      4'd2: segs = 7'b0100100;
      4'd3: segs = 7'b0110000;
      4'd4: segs = 7'b0011001;
      4'd5: segs = 7'b0010010;
      4'd6: segs = 7'b0000010;
      4'd7: segs = 7'b1111000;
      4'd8: segs = 7'b0000000;
      4'd9: segs = 7'b0010000;
      default: segs = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/peripheral_bcd_scan.sv
// peripheral_bcd_scan: bus-mapped binary-to-BCD converter driving a multiplexed 7-segment display
module peripheral_bcd_scan
  import peripheral_bcd_scan_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DATA_W = 16,
  parameter int tamPro = 16,
  parameter int tamAddr = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               wr,
  input  logic               rd,
  input  logic [tamAddr-1:0] addr,
  input  logic [tamPro-1:0]  din,
  output logic [tamPro-1:0]  dout,
  output logic [6:0]         segs,
  output logic               dp,
  output logic [7:0]         anode
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int BCD_W = 4*BCD_N;
  state_t state_q, state_d;
  logic [DATA_W-1:0] value_q, value_d, sh_q, sh_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [4:0] n_q, n_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [DIGITS-1:0] dpmask_q, dpmask_d;
  logic lzb_q, lzb_d, en_q, en_d, done_q, done_d, ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [6:0] segs_q, segs_d, seg_dec;
  logic dp_q, dp_d;
  logic [7:0] anode_q, anode_d, dpm8;
  logic [31:0] buf32;
  logic [2:0] status;
  logic we, re, wr_ctrl, start, busy, blank;
  always_comb begin
    we = cs && wr;
    re = cs && rd;
    busy = state_q != IDLE;
    wr_ctrl = we && addr == tamAddr'(ADDR_CTRL);
    start = wr_ctrl && din[0] && !busy;
    value_d = (we && addr == tamAddr'(ADDR_VALUE)) ? DATA_W'(din) : value_q;
    dpmask_d = (we && addr == tamAddr'(ADDR_DPMASK)) ? DIGITS'(din) : dpmask_q;
    lzb_d = wr_ctrl ? din[1] : lzb_q;
    en_d = wr_ctrl ? din[2] : en_q;
    state_d = state_q;
    sh_d = sh_q;
    bcd_d = bcd_q;
    n_d = n_q;
    buf_d = buf_q;
    ovf_d = ovf_q;
    // a completion in the same cycle as a STATUS read wins: that read never saw DONE
    done_d = (re && addr == tamAddr'(ADDR_STATUS)) ? 1'b0 : done_q;
    if (start) begin
      state_d = SHIFT;
      sh_d = value_q;
      bcd_d = '0;
      n_d = '0;
    end else if (state_q == SHIFT) begin
      bcd_d = BCD_W'({dabble(bcd_q), sh_q[DATA_W-1]});
      sh_d = sh_q << 1;
      n_d = n_q + 5'd1;
      state_d = (n_q == 5'(DATA_W-1)) ? DONE_ST : SHIFT;
    end else if (state_q == DONE_ST) begin
      buf_d = BW'(bcd_q);
      ovf_d = |(bcd_q >> BW);
      done_d = 1'b1;
      state_d = IDLE;
    end
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done_q;
    status[ST_OVF] = ovf_q;
    dout = !re ? '0 :
           addr == tamAddr'(ADDR_VALUE) ? tamPro'(value_q) :
           addr == tamAddr'(ADDR_DPMASK) ? tamPro'(dpmask_q) :
           addr == tamAddr'(ADDR_STATUS) ? tamPro'(status) : '0;
  end
  bcd_seg_decode u_dec (.digit(buf32[{idx_q, 2'b00} +: 4]), .segs(seg_dec));
  always_comb begin
    cnt_d = (cnt_q == CW'(SCAN_DIV-1)) ? '0 : cnt_q + CW'(1);
    idx_d = (cnt_q != CW'(SCAN_DIV-1)) ? idx_q : (idx_q == 3'(DIGITS-1)) ? 3'd0 : idx_q + 3'd1;
    buf32 = 32'(buf_q);
    dpm8 = 8'(dpmask_q);
    // blank when nothing non-zero sits at or above this digit
    blank = lzb_q && idx_q != 3'd0 && (buf32 >> {idx_q, 2'b00}) == 32'd0;
    segs_d = ovf_q ? SEG_DASH : blank ? SEG_BLANK : seg_dec;
    dp_d = ~dpm8[idx_q];
    anode_d = en_q ? ~(8'd1 << idx_q) : 8'hFF;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      value_q <= '0;
      sh_q <= '0;
      bcd_q <= '0;
      n_q <= '0;
      buf_q <= '0;
      dpmask_q <= '0;
      lzb_q <= 1'b0;
      en_q <= 1'b1;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      segs_q <= 7'b1000000;
      dp_q <= 1'b1;
      anode_q <= 8'hFE;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      n_q <= n_d;
      buf_q <= buf_d;
      dpmask_q <= dpmask_d;
      lzb_q <= lzb_d;
      en_q <= en_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      segs_q <= segs_d;
      dp_q <= dp_d;
      anode_q <= anode_d;
    end
  end
  assign segs = segs_q;
  assign dp = dp_q;
  assign anode = anode_q;
endmodule

// File: tb/tb_peripheral_bcd_scan.sv
// tb_peripheral_bcd_scan: scoreboard bench for a 4-digit, 16-bit, fast-scan configuration
module tb_peripheral_bcd_scan;
  localparam int DIGITS = 4;
  localparam int DATA_W = 16;
  logic clk = 1'b0;
  logic rst, cs, wr, rd;
  logic [3:0] addr;
  logic [15:0] din, dout;
  logic [6:0] segs;
  logic dp;
  logic [7:0] anode;
  always #5 clk = ~clk;
  peripheral_bcd_scan #(.DIGITS(DIGITS), .DATA_W(DATA_W), .tamPro(16), .tamAddr(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .din(din),
    .dout(dout), .segs(segs), .dp(dp), .anode(anode)
  );
  typedef struct packed {
    logic ovf;
    logic [3:0] dpm;
    logic [27:0] segs;
  } exp_t;
  exp_t sb[$];
  int pass_cnt = 0;
  int tot_cnt = 0;
  logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic exp_t model(input int v, input bit lzb, input logic [3:0] dpm);
    exp_t e;
    int d[4];
    int msd = 0;
    int p = 1;
    for (int k = 0; k < 4; k++) begin
      d[k] = (v / p) % 10;
      p = p * 10;
      if (d[k] != 0) msd = k;
    end
    e.ovf = v >= 10000;
    e.dpm = dpm;
    for (int k = 0; k < 4; k++) e.segs[7*k +: 7] = e.ovf ? 7'h3F : (lzb && k > msd) ? 7'h7F : tbl[d[k]];
    return e;
  endfunction

  task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
    cs = 1; wr = 1; addr = a; din = d;
    @(negedge clk);
    cs = 0; wr = 0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [15:0] d);
    cs = 1; rd = 1; addr = a;
    #1 d = dout;
    @(negedge clk);
    cs = 0; rd = 0;
  endtask

  task automatic wait_done(output int n, output logic [15:0] first, output logic [15:0] s);
    n = 0;
    s = '0;
    first = '0;
    while (!s[1] && n < 200) begin
      bus_rd(4'h6, s);
      if (n == 0) first = s;
      n++;
    end
  endtask

  task automatic check_display(input exp_t e, input string tag);
    logic [7:0] a_exp;
    int w;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      a_exp = ~(8'h01 << k);
      w = 0;
      while (anode !== a_exp && w < 40) begin
        @(negedge clk);
        w++;
      end
      tot_cnt++;
      if (anode !== a_exp || segs !== e.segs[7*k +: 7])
        $display("FAIL %s digit%0d: anode=%h segs=%b, required anode=%h segs=%b", tag, k, anode, segs, a_exp, e.segs[7*k +: 7]);
      else pass_cnt++;
      tot_cnt++;
      if (dp !== ~e.dpm[k]) $display("FAIL %s dp%0d: got %b, required %b", tag, k, dp, ~e.dpm[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset;
    logic [15:0] s;
    #1;
    tot_cnt++;
    if (anode !== 8'hFE || segs !== 7'b1000000 || dp !== 1'b1)
      $display("FAIL reset_outputs: anode=%h segs=%b dp=%b, required FE 1000000 1", anode, segs, dp);
    else pass_cnt++;
    @(negedge clk);
    bus_rd(4'h6, s);
    tot_cnt++;
    if (s !== 16'h0) $display("FAIL reset_status: got %h, required 0000", s); else pass_cnt++;
    bus_rd(4'h2, s);
    tot_cnt++;
    if (s !== 16'h0) $display("FAIL reset_value: got %h, required 0000", s); else pass_cnt++;
  endtask

  task automatic test_regs;
    logic [15:0] s;
    bus_wr(4'h2, 16'hBEEF);
    bus_rd(4'h2, s);
    tot_cnt++;
    if (s !== 16'hBEEF) $display("FAIL value_rw: got %h, required BEEF", s); else pass_cnt++;
    bus_wr(4'h4, 16'hFFF5);
    bus_rd(4'h4, s);
    tot_cnt++;
    if (s !== 16'h0005) $display("FAIL dpmask_rw: got %h, required 0005", s); else pass_cnt++;
    bus_wr(4'h8, 16'h1111);
    bus_rd(4'h2, s);
    tot_cnt++;
    if (s !== 16'hBEEF) $display("FAIL unmapped_wr: value %h, required BEEF", s); else pass_cnt++;
    bus_rd(4'h0, s);
    tot_cnt++;
    if (s !== 16'h0) $display("FAIL ctrl_rd: got %h, required 0000", s); else pass_cnt++;
    rd = 1; addr = 4'h2;
    #1;
    tot_cnt++;
    if (dout !== 16'h0) $display("FAIL rd_no_cs: got %h, required 0000", dout); else pass_cnt++;
    rd = 0;
    bus_wr(4'h4, 16'h0);
  endtask

  task automatic test_convert(input int v, input bit lzb, input logic [3:0] dpm);
    logic [15:0] first, s;
    int n;
    exp_t e;
    bus_wr(4'h4, {12'h0, dpm});
    bus_wr(4'h2, v[15:0]);
    bus_wr(4'h0, {13'h0, 1'b1, lzb, 1'b0});
    sb.push_back(model(v, lzb, dpm));
    bus_wr(4'h0, {13'h0, 1'b1, lzb, 1'b1});
    wait_done(n, first, s);
    e = sb.pop_front();
    tot_cnt++;
    if (first[0] !== 1'b1) $display("FAIL busy_%0d: BUSY %b after start, required 1", v, first[0]); else pass_cnt++;
    tot_cnt++;
    if (n - 1 != DATA_W + 1 || s[0] !== 1'b0)
      $display("FAIL latency_%0d: %0d clocks busy=%b, required %0d busy=0", v, n - 1, s[0], DATA_W + 1);
    else pass_cnt++;
    tot_cnt++;
    if (s[2] !== e.ovf) $display("FAIL ovf_%0d: got %b, required %b", v, s[2], e.ovf); else pass_cnt++;
    check_display(e, $sformatf("conv_%0d_lzb%0d", v, lzb));
  endtask

  task automatic test_back_to_back;
    logic [15:0] first, s;
    int n;
    int extra = 0;
    exp_t e;
    bus_wr(4'h0, 16'h4);
    bus_wr(4'h2, 16'd4321);
    sb.push_back(model(4321, 1'b0, 4'h0));
    bus_wr(4'h0, 16'h5);
    repeat (3) @(negedge clk);
    bus_wr(4'h0, 16'h5);
    bus_wr(4'h2, 16'd999);
    wait_done(n, first, s);
    e = sb.pop_front();
    tot_cnt++;
    if (s[1] !== 1'b1 || s[2] !== e.ovf) $display("FAIL b2b_done: status %h, required DONE=1 OVF=%b", s, e.ovf); else pass_cnt++;
    for (int i = 0; i < 30; i++) begin
      bus_rd(4'h6, s);
      if (s[1] || s[0]) extra++;
    end
    tot_cnt++;
    if (extra != 0) $display("FAIL b2b_single: %0d busy/done reads after first DONE, required 0", extra); else pass_cnt++;
    bus_rd(4'h2, s);
    tot_cnt++;
    if (s !== 16'd999) $display("FAIL b2b_value: got %0d, required 999", s); else pass_cnt++;
    check_display(e, "b2b");
  endtask

  task automatic test_scan;
    logic [7:0] a_exp;
    int w = 0;
    while (anode !== 8'hF7 && w < 40) begin @(negedge clk); w++; end
    while (anode !== 8'hFE && w < 80) begin @(negedge clk); w++; end
    for (int i = 0; i < 16; i++) begin
      a_exp = ~(8'h01 << (i / 4));
      tot_cnt++;
      if (anode !== a_exp) $display("FAIL scan_%0d: anode %h, required %h", i, anode, a_exp); else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_enable;
    bus_wr(4'h0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tot_cnt++;
      if (anode !== 8'hFF) $display("FAIL en_off_%0d: anode %h, required FF", i, anode); else pass_cnt++;
    end
    bus_wr(4'h0, 16'h4);
    test_scan();
  endtask

  task automatic test_reset_mid;
    logic [15:0] s;
    int seen = 0;
    bus_wr(4'h2, 16'd1234);
    bus_wr(4'h0, 16'h5);
    repeat (9) @(negedge clk);
    #2 rst = 1;
    cs = 1; rd = 1; addr = 4'h6;
    #1;
    tot_cnt++;
    if (anode !== 8'hFE || dout !== 16'h0) $display("FAIL rst_mid: anode %h status %h, required FE 0000", anode, dout); else pass_cnt++;
    cs = 0; rd = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 30; i++) begin
      bus_rd(4'h6, s);
      if (s !== 16'h0) seen++;
    end
    tot_cnt++;
    if (seen != 0) $display("FAIL rst_mid_status: %0d non-zero status reads, required 0", seen); else pass_cnt++;
    sb.push_back(model(0, 1'b0, 4'h0));
    check_display(sb.pop_front(), "rst_mid");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1; cs = 0; wr = 0; rd = 0; addr = '0; din = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    test_reset();
    test_regs();
    test_convert(1234, 1'b0, 4'h0);
    test_convert(1234, 1'b1, 4'b0101);
    test_convert(12, 1'b1, 4'h0);
    test_convert(0, 1'b1, 4'h0);
    test_convert(9999, 1'b0, 4'h0);
    test_convert(10000, 1'b0, 4'h0);
    test_convert(65535, 1'b0, 4'b1000);
    test_convert(7, 1'b0, 4'h0);
    test_back_to_back();
    test_scan();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
